// File: rtl/obstacle_loader.sv
// obstacle_loader: per-frame scan of the obstacle ROM. Each record holds a
// header word and V vertex words. The loader keeps the first MAX_OBSTACLES_ON_SCREEN
// valid (and, with culling, visible) records and publishes them atomically to
// the renderer, pulsing done_out on the single cycle the outputs change.
// Optional feature macro: OBSTACLE_CULL_EN enables bounding-box culling against
// the camera view. Without it, every record with at least 3 sides is accepted.
`timescale 1ns/1ps
module obstacle_loader #(
  parameter int PIXEL_WIDTH             = 1280,
  parameter int PIXEL_HEIGHT            = 720,
  parameter int SCALE_LEVEL             = 0,
  parameter int WORLD_BITS              = 32,
  parameter int MAX_OBSTACLES_ON_SCREEN = 4,
  parameter int OBSTACLE_MAX_VERTICES   = 8,
  parameter int NUM_OBSTACLES           = 64,
  parameter int MEM_LATENCY             = 2
) (
  input  logic                                                   clk_in,
  input  logic                                                   rst_in,
  input  logic                                                   frame_start_in,
  input  logic signed [WORLD_BITS-1:0]                           camera_x_in,
  input  logic signed [WORLD_BITS-1:0]                           camera_y_in,
  output logic [$clog2(NUM_OBSTACLES*(OBSTACLE_MAX_VERTICES+1))-1:0] mem_addr_out,
  input  logic [2*WORLD_BITS-1:0]                                mem_data_in,
  output logic signed [WORLD_BITS-1:0]                           obstacles_xs_out [MAX_OBSTACLES_ON_SCREEN][OBSTACLE_MAX_VERTICES],
  output logic signed [WORLD_BITS-1:0]                           obstacles_ys_out [MAX_OBSTACLES_ON_SCREEN][OBSTACLE_MAX_VERTICES],
  output logic [$clog2(OBSTACLE_MAX_VERTICES+1)-1:0]             polygons_num_sides_out [MAX_OBSTACLES_ON_SCREEN],
  output logic [3:0]                                             colors_out [MAX_OBSTACLES_ON_SCREEN],
  output logic [$clog2(MAX_OBSTACLES_ON_SCREEN+1)-1:0]           num_polygons_out,
  output logic                                                   busy_out,
  output logic                                                   done_out,
  output logic                                                   overflow_out
);

  localparam int W    = WORLD_BITS;
  localparam int V    = OBSTACLE_MAX_VERTICES;
  localparam int MAXS = MAX_OBSTACLES_ON_SCREEN;
  localparam int ML   = MEM_LATENCY;
  localparam int NSB  = $clog2(V+1);
  localparam int AW   = $clog2(NUM_OBSTACLES*(V+1));
  localparam int SW   = $clog2(MAXS+1);
  localparam int RW   = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_NEXT, S_PUBLISH} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d, done_q, done_d, ovf_out_q, ovf_out_d;
  logic [SW-1:0]         num_out_q, num_out_d;
  logic signed [W-1:0]   xs_out_q [MAXS][V], xs_out_d [MAXS][V];
  logic signed [W-1:0]   ys_out_q [MAXS][V], ys_out_d [MAXS][V];
  logic [NSB-1:0]        sides_out_q [MAXS], sides_out_d [MAXS];
  logic [3:0]            color_out_q [MAXS], color_out_d [MAXS];
  logic signed [W-1:0]   sh_xs_q [MAXS][V], sh_xs_d [MAXS][V];
  logic signed [W-1:0]   sh_ys_q [MAXS][V], sh_ys_d [MAXS][V];
  logic [NSB-1:0]        sh_sides_q [MAXS], sh_sides_d [MAXS];
  logic [3:0]            sh_color_q [MAXS], sh_color_d [MAXS];
  logic [SW-1:0]         slot_cnt_q, slot_cnt_d;
  logic                  ovf_acc_q, ovf_acc_d;
  logic [RW-1:0]         rec_q, rec_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  iss_vld_q, iss_vld_d;
  logic [NSB-1:0]        iss_idx_q, iss_idx_d;
  logic [ML:1]           tag_vld_q, tag_vld_d;
  logic [NSB-1:0]        tag_idx_q [1:ML], tag_idx_d [1:ML];
  logic signed [W-1:0]   stg_xs_q [V], stg_xs_d [V];
  logic signed [W-1:0]   stg_ys_q [V], stg_ys_d [V];
  logic [NSB-1:0]        stg_sides_q, stg_sides_d;
  logic [3:0]            stg_color_q, stg_color_d;
  logic                  vis;
  logic signed [W-1:0]   vx, vy;

`ifdef OBSTACLE_CULL_EN
  localparam logic signed [W:0] HALF_W = $signed((W+1)'((PIXEL_WIDTH  >> SCALE_LEVEL) / 2));
  localparam logic signed [W:0] HALF_H = $signed((W+1)'((PIXEL_HEIGHT >> SCALE_LEVEL) / 2));

  logic signed [W-1:0]   cam_x_q, cam_x_d, cam_y_q, cam_y_d;
  logic signed [W-1:0]   min_x_q, min_x_d, max_x_q, max_x_d;
  logic signed [W-1:0]   min_y_q, min_y_d, max_y_q, max_y_d;

  // One extra bit of headroom so the window edges never wrap.
  function automatic logic signed [W:0] sx(input logic signed [W-1:0] v);
    return {v[W-1], v};
  endfunction

  function automatic logic overlap(input logic signed [W:0] lo, input logic signed [W:0] hi,
                                   input logic signed [W:0] c,  input logic signed [W:0] half);
    return (hi >= c - half) && (lo < c + half);
  endfunction
`else
  logic unused_cam;
  assign unused_cam = ^{camera_x_in, camera_y_in};
`endif

  assign vx = mem_data_in[2*W-1:W];
  assign vy = mem_data_in[W-1:0];

  // Accept decision for the record sitting in the staging buffer.
  always_comb begin
    vis = (stg_sides_q >= NSB'(3));
`ifdef OBSTACLE_CULL_EN
    vis = vis && overlap(sx(min_x_q), sx(max_x_q), sx(cam_x_q), HALF_W)
              && overlap(sx(min_y_q), sx(max_y_q), sx(cam_y_q), HALF_H);
`endif
  end

  // Next-state logic: fetch pipeline, staging capture, slot selection, publish.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_out_d   = ovf_out_q;
    num_out_d   = num_out_q;
    xs_out_d    = xs_out_q;
    ys_out_d    = ys_out_q;
    sides_out_d = sides_out_q;
    color_out_d = color_out_q;
    sh_xs_d     = sh_xs_q;
    sh_ys_d     = sh_ys_q;
    sh_sides_d  = sh_sides_q;
    sh_color_d  = sh_color_q;
    slot_cnt_d  = slot_cnt_q;
    ovf_acc_d   = ovf_acc_q;
    rec_d       = rec_q;
    addr_d      = addr_q;
    iss_vld_d   = iss_vld_q;
    iss_idx_d   = iss_idx_q;
    stg_xs_d    = stg_xs_q;
    stg_ys_d    = stg_ys_q;
    stg_sides_d = stg_sides_q;
    stg_color_d = stg_color_q;
`ifdef OBSTACLE_CULL_EN
    cam_x_d = cam_x_q;
    cam_y_d = cam_y_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
`endif

    // Request tags ride alongside the ROM latency so data lands with its word index.
    tag_vld_d[1] = iss_vld_q;
    tag_idx_d[1] = iss_idx_q;
    for (int j = 2; j <= ML; j++) begin
      tag_vld_d[j] = tag_vld_q[j-1];
      tag_idx_d[j] = tag_idx_q[j-1];
    end

    if (tag_vld_q[ML]) begin
      if (tag_idx_q[ML] == '0) begin
        stg_color_d = mem_data_in[3:0];
        stg_sides_d = mem_data_in[4+NSB-1:4];
      end
      for (int k = 0; k < V; k++) begin
        if (tag_idx_q[ML] == NSB'(k+1)) begin
          if (NSB'(k) < stg_sides_q) begin
            stg_xs_d[k] = vx;
            stg_ys_d[k] = vy;
`ifdef OBSTACLE_CULL_EN
            if (k == 0) begin
              min_x_d = vx;
              max_x_d = vx;
              min_y_d = vy;
              max_y_d = vy;
            end else begin
              min_x_d = (vx < min_x_q) ? vx : min_x_q;
              max_x_d = (vx > max_x_q) ? vx : max_x_q;
              min_y_d = (vy < min_y_q) ? vy : min_y_q;
              max_y_d = (vy > max_y_q) ? vy : max_y_q;
            end
`endif
          end else begin
            stg_xs_d[k] = '0;
            stg_ys_d[k] = '0;
          end
        end
      end
    end

    case (state_q)
      S_IDLE, S_PUBLISH: begin
        state_d = S_IDLE;
        if (frame_start_in) begin
`ifdef OBSTACLE_CULL_EN
          cam_x_d = camera_x_in;
          cam_y_d = camera_y_in;
`endif
          slot_cnt_d = '0;
          ovf_acc_d  = 1'b0;
          rec_d      = '0;
          addr_d     = '0;
          iss_vld_d  = 1'b1;
          iss_idx_d  = '0;
          busy_d     = 1'b1;
          sh_xs_d    = '{default: '0};
          sh_ys_d    = '{default: '0};
          sh_sides_d = '{default: '0};
          sh_color_d = '{default: '0};
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (iss_vld_q) begin
          if (iss_idx_q == NSB'(V)) begin
            iss_vld_d = 1'b0;
          end else begin
            iss_idx_d = iss_idx_q + 1'b1;
            addr_d    = addr_q + 1'b1;
          end
        end
        if (tag_vld_q[ML] && tag_idx_q[ML] == NSB'(V)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (vis) begin
          if (slot_cnt_q == SW'(MAXS)) begin
            ovf_acc_d = 1'b1;
          end else begin
            for (int s = 0; s < MAXS; s++) begin
              if (slot_cnt_q == SW'(s)) begin
                sh_xs_d[s]    = stg_xs_q;
                sh_ys_d[s]    = stg_ys_q;
                sh_sides_d[s] = stg_sides_q;
                sh_color_d[s] = stg_color_q;
              end
            end
            slot_cnt_d = slot_cnt_q + 1'b1;
          end
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (rec_q == RW'(NUM_OBSTACLES-1)) begin
          xs_out_d    = sh_xs_q;
          ys_out_d    = sh_ys_q;
          sides_out_d = sh_sides_q;
          color_out_d = sh_color_q;
          num_out_d   = slot_cnt_q;
          ovf_out_d   = ovf_acc_q;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_PUBLISH;
        end else begin
          rec_d     = rec_q + 1'b1;
          addr_d    = addr_q + 1'b1;
          iss_vld_d = 1'b1;
          iss_idx_d = '0;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, including published outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_out_q   <= 1'b0;
      num_out_q   <= '0;
      xs_out_q    <= '{default: '0};
      ys_out_q    <= '{default: '0};
      sides_out_q <= '{default: '0};
      color_out_q <= '{default: '0};
      sh_xs_q     <= '{default: '0};
      sh_ys_q     <= '{default: '0};
      sh_sides_q  <= '{default: '0};
      sh_color_q  <= '{default: '0};
      slot_cnt_q  <= '0;
      ovf_acc_q   <= 1'b0;
      rec_q       <= '0;
      addr_q      <= '0;
      iss_vld_q   <= 1'b0;
      iss_idx_q   <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '{default: '0};
      stg_xs_q    <= '{default: '0};
      stg_ys_q    <= '{default: '0};
      stg_sides_q <= '0;
      stg_color_q <= '0;
`ifdef OBSTACLE_CULL_EN
      cam_x_q <= '0;
      cam_y_q <= '0;
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_out_q   <= ovf_out_d;
      num_out_q   <= num_out_d;
      xs_out_q    <= xs_out_d;
      ys_out_q    <= ys_out_d;
      sides_out_q <= sides_out_d;
      color_out_q <= color_out_d;
      sh_xs_q     <= sh_xs_d;
      sh_ys_q     <= sh_ys_d;
      sh_sides_q  <= sh_sides_d;
      sh_color_q  <= sh_color_d;
      slot_cnt_q  <= slot_cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      rec_q       <= rec_d;
      addr_q      <= addr_d;
      iss_vld_q   <= iss_vld_d;
      iss_idx_q   <= iss_idx_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      stg_xs_q    <= stg_xs_d;
      stg_ys_q    <= stg_ys_d;
      stg_sides_q <= stg_sides_d;
      stg_color_q <= stg_color_d;
`ifdef OBSTACLE_CULL_EN
      cam_x_q <= cam_x_d;
      cam_y_q <= cam_y_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
`endif
    end
  end

  assign mem_addr_out           = addr_q;
  assign obstacles_xs_out       = xs_out_q;
  assign obstacles_ys_out       = ys_out_q;
  assign polygons_num_sides_out = sides_out_q;
  assign colors_out             = color_out_q;
  assign num_polygons_out       = num_out_q;
  assign busy_out               = busy_q;
  assign done_out               = done_q;
  assign overflow_out           = ovf_out_q;

endmodule

// File: tb/tb_obstacle_loader.sv
// Directed bench for obstacle_loader with a small ROM and a 2-cycle read model.
`timescale 1ns/1ps
module tb_obstacle_loader;

  localparam int V    = 8;
  localparam int MAXS = 4;
  localparam int NUM  = 8;
  localparam int WPR  = V + 1;
  localparam int LAT  = NUM * (V + 1 + 2 + 2) + 1;
`ifdef OBSTACLE_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               frame_start_in = 1'b0;
  logic signed [31:0] camera_x_in = '0;
  logic signed [31:0] camera_y_in = '0;
  logic [6:0]         mem_addr_out;
  logic [63:0]        mem_data_in;
  logic signed [31:0] xs [MAXS][V];
  logic signed [31:0] ys [MAXS][V];
  logic [3:0]         sides [MAXS];
  logic [3:0]         colors [MAXS];
  logic [2:0]         num_polygons_out;
  logic               busy_out, done_out, overflow_out;

  logic [63:0] rom [NUM*WPR];
  logic [63:0] rd1, rd2;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int chg_cnt = 0;
  logic [2:0]         prev_num = '0;
  logic signed [31:0] prev_x = '0;
  logic               prev_ovf = 1'b0;

  obstacle_loader #(.NUM_OBSTACLES(NUM)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .camera_x_in(camera_x_in), .camera_y_in(camera_y_in),
    .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
    .obstacles_xs_out(xs), .obstacles_ys_out(ys),
    .polygons_num_sides_out(sides), .colors_out(colors),
    .num_polygons_out(num_polygons_out), .busy_out(busy_out),
    .done_out(done_out), .overflow_out(overflow_out)
  );

  always #5 clk_in = ~clk_in;

  // ROM model: word for the address presented in cycle c is on the bus in cycle c+2.
  always @(posedge clk_in) begin
    rd1 <= rom[int'(mem_addr_out)];
    rd2 <= rd1;
  end
  assign mem_data_in = rd2;

  // Counts done pulses and any output change that is not accompanied by done.
  always @(negedge clk_in) begin
    if (done_out) done_cnt++;
    if (!done_out && !rst_in &&
        (num_polygons_out !== prev_num || xs[0][0] !== prev_x || overflow_out !== prev_ovf))
      chg_cnt++;
    prev_num = num_polygons_out;
    prev_x   = xs[0][0];
    prev_ovf = overflow_out;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < NUM*WPR; i++) rom[i] = {32'sd999, 32'sd999};
    for (int r = 0; r < NUM; r++) rom[r*WPR] = '0;
  endtask

  task automatic set_hdr(input int r, input int color, input int nsides);
    rom[r*WPR] = {56'd0, 4'(nsides), 4'(color)};
  endtask

  task automatic set_vtx(input int r, input int k, input logic signed [31:0] x, input logic signed [31:0] y);
    rom[r*WPR+1+k] = {x, y};
  endtask

  task automatic put_square(input int r, input int color, input int x0, input int x1,
                            input int y0, input int y1, input int jx, input int jy);
    set_hdr(r, color, 4);
    set_vtx(r, 0, x0, y0);
    set_vtx(r, 1, x1, y0);
    set_vtx(r, 2, x1, y1);
    set_vtx(r, 3, x0, y1);
    for (int k = 4; k < V; k++) set_vtx(r, k, jx, jy);
  endtask

  task automatic load_rom_a();
    clear_rom();
    put_square(0, 1, 0, 100, 0, 100, 777, -777);
    put_square(1, 2, 500, 600, 0, 100, 777, -777);
    put_square(2, 3, 5000, 5100, 0, 100, 777, -777);
  endtask

  // Starts a scan and waits (bounded) for done; checks the start-to-done latency.
  task automatic run_frame(input int cx, input int cy, input string tag);
    int n;
    camera_x_in = cx;
    camera_y_in = cy;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    n = 0;
    while (!done_out && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, done_out ? n + 1 : -1, LAT);
  endtask

  initial begin
    int base_done;
    int base_chg;
    int n;
    clear_rom();
    repeat (3) tick();
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_num", num_polygons_out, 0);
    chk("rst_ovf", overflow_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    rst_in = 1'b0;
    tick();

    // Three squares around the origin, near, near-ish and far.
    load_rom_a();
    run_frame(0, 0, "t1");
    chk("t1_num", num_polygons_out, CULL ? 2 : 3);
    chk("t1_ovf", overflow_out, 0);
    chk("t1_busy", busy_out, 0);
    chk("t1_s0_x1", xs[0][1], 100);
    chk("t1_s0_y2", ys[0][2], 100);
    chk("t1_s0_sides", sides[0], 4);
    chk("t1_s0_col", colors[0], 1);
    chk("t1_s0_x4_zero", xs[0][4], 0);
    chk("t1_s0_y7_zero", ys[0][7], 0);
    chk("t1_s1_x0", xs[1][0], 500);
    chk("t1_s1_col", colors[1], 2);
    chk("t1_s2_x0", xs[2][0], CULL ? 0 : 5000);
    chk("t1_s2_sides", sides[2], CULL ? 0 : 4);
    chk("t1_s2_col", colors[2], CULL ? 0 : 3);
    chk("t1_s3_sides", sides[3], 0);
    tick();

    // Reset 50 cycles into a scan clears published data and cancels the scan.
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    repeat (50) tick();
    chk("rs_busy_mid", busy_out, 1);
    rst_in = 1'b1;
    #2;
    chk("rs_busy", busy_out, 0);
    chk("rs_num", num_polygons_out, 0);
    chk("rs_s0_x1", xs[0][1], 0);
    chk("rs_s1_col", colors[1], 0);
    chk("rs_s0_sides", sides[0], 0);
    tick();
    rst_in = 1'b0;
    base_done = done_cnt;
    repeat (150) tick();
    chk("rs_no_done", done_cnt - base_done, 0);
    chk("rs_busy_after", busy_out, 0);

    // Six valid squares plus a 2-sided and a 3-sided record; only four slots.
    clear_rom();
    for (int r = 0; r < 6; r++) put_square(r, r + 1, 10*r, 10*r + 50, 0, 50, 0, 0);
    set_hdr(6, 9, 2);
    set_hdr(7, 10, 3);
    run_frame(0, 0, "t2");
    chk("t2_num", num_polygons_out, 4);
    chk("t2_ovf", overflow_out, 1);
    chk("t2_s3_col", colors[3], 4);
    chk("t2_s3_x0", xs[3][0], 30);
    chk("t2_s2_x1", xs[2][1], 70);
    tick();

    // 2-sided record skipped; 3-sided record published with trailing vertices zero.
    clear_rom();
    set_hdr(0, 5, 2);
    set_vtx(0, 0, 1, 1);
    set_vtx(0, 1, 2, 2);
    set_hdr(1, 6, 3);
    set_vtx(1, 0, 1, 2);
    set_vtx(1, 1, 30, -4);
    set_vtx(1, 2, -7, 40);
    run_frame(0, 0, "t3");
    chk("t3_num", num_polygons_out, 1);
    chk("t3_ovf", overflow_out, 0);
    chk("t3_s0_sides", sides[0], 3);
    chk("t3_s0_col", colors[0], 6);
    chk("t3_s0_x2", xs[0][2], -7);
    chk("t3_s0_y1", ys[0][1], -4);
    chk("t3_s0_x3_zero", xs[0][3], 0);
    chk("t3_s0_y3_zero", ys[0][3], 0);
    chk("t3_s1_sides_cleared", sides[1], 0);
    tick();

    // Left window edge with camera x = -2000: maxx = -2640 in, maxx = -2641 out.
    clear_rom();
    put_square(0, 7, -2740, -2640, 0, 100, -2000, 0);
    run_frame(-2000, 0, "t4a");
    chk("t4a_num", num_polygons_out, 1);
    chk("t4a_s0_x1", xs[0][1], -2640);
    tick();
    clear_rom();
    put_square(0, 7, -2741, -2641, 0, 100, -2000, 0);
    run_frame(-2000, 0, "t4b");
    chk("t4b_num", num_polygons_out, CULL ? 0 : 1);
    tick();

    // A second frame_start while busy is ignored; camera stays as first latched.
    load_rom_a();
    base_done = done_cnt;
    base_chg = chg_cnt;
    camera_x_in = 0;
    camera_y_in = 0;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    repeat (20) tick();
    camera_x_in = 100000;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    n = 0;
    while (!done_out && n < 400) begin
      tick();
      n++;
    end
    chk("t5_done_seen", done_out, 1);
    chk("t5_num", num_polygons_out, CULL ? 2 : 3);
    chk("t5_s2_x0", xs[2][0], CULL ? 0 : 5000);
    repeat (150) tick();
    chk("t5_one_done", done_cnt - base_done, 1);
    chk("t5_stable", chg_cnt - base_chg, 0);
    chk("t5_idle", busy_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
